// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
// Module   : cp0_unit
// Purpose  : Coprocessor-0 register file and exception/interrupt controller.
//            Holds SR (12), Cause (13), EPC (14) and PRId (15), raises a
//            single-cycle combinational request that flushes the pipeline
//            and redirects fetch to the handler, serves mfc0/mtc0 and
//            clears EXL on eret.
// Ports    : clk, reset_n (sync, active-low)
//            A1 -> DOut        : mfc0 read port (combinational)
//            A2, DIn, WE       : mtc0 write port
//            EPC_in, BD_in,
//            ExcCode_in        : victim instruction information (E stage)
//            HWInt             : level-sensitive external interrupt lines
//            EXLClr            : eret committing this cycle
//            IntReq            : take exception/interrupt now
//            EPC_out           : EPC register, eret target
// Options  : define CP0_TIMER_EN to add Count (9) / Compare (11) and the
//            timer interrupt merged onto line 5.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_unit #(
  parameter logic [31:0] PRID_VAL   = 32'h0000_2019,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] EPC_in,
  input  logic        BD_in,
  input  logic [4:0]  ExcCode_in,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC_out,
  output logic [31:0] DOut
);

  localparam logic [4:0] c_reg_count   = 5'd9;
  localparam logic [4:0] c_reg_compare = 5'd11;
  localparam logic [4:0] c_reg_sr      = 5'd12;
  localparam logic [4:0] c_reg_cause   = 5'd13;
  localparam logic [4:0] c_reg_epc     = 5'd14;
  localparam logic [4:0] c_reg_prid    = 5'd15;

  // Architectural state
  logic [5:0]  r_sr_im;
  logic        r_sr_exl;
  logic        r_sr_ie;
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip;
  logic [4:0]  r_cause_exc;
  logic [31:0] r_epc;

  logic [5:0]  w_int_lines;
  logic        w_int_pend;
  logic        w_exc_pend;
  logic        w_mtc0;
  logic        w_wr_sr;
  logic        w_wr_epc;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  // HANDLER_PC is documentation only and the low EPC_in bits are dropped by
  // word alignment; fold them into a deliberately unused net.
  logic        w_unused_ok;
  assign w_unused_ok = ^{HANDLER_PC, EPC_in[1:0]};

`ifdef CP0_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic        w_wr_count;
  logic        w_wr_compare;

  assign w_int_lines  = HWInt | {r_ti, 5'b0_0000};
  assign w_wr_count   = w_mtc0 && (A2 == c_reg_count);
  assign w_wr_compare = w_mtc0 && (A2 == c_reg_compare);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_ti      <= 1'b0;
    end else begin
      // An mtc0 to Count replaces this cycle's increment.
      if (w_wr_count) r_count <= DIn;
      else            r_count <= r_count + 32'd1;

      if (w_wr_compare) r_compare <= DIn;

      // Compare write acknowledges the timer; otherwise TI is sticky.
      if (w_wr_compare)
        r_ti <= 1'b0;
      else if ((r_count == r_compare) && (r_compare != 32'd0))
        r_ti <= 1'b1;
    end
  end
`else
  assign w_int_lines = HWInt;
`endif

  // Request generation: nothing is taken while EXL is set (no nesting).
  assign w_int_pend = (|(w_int_lines & r_sr_im)) & r_sr_ie & ~r_sr_exl;
  assign w_exc_pend = (ExcCode_in != 5'd0) & ~r_sr_exl;
  assign IntReq     = w_int_pend | w_exc_pend;

  // A taken request discards the mtc0 in the same cycle entirely.
  assign w_mtc0   = WE & ~IntReq;
  assign w_wr_sr  = w_mtc0 && (A2 == c_reg_sr);
  assign w_wr_epc = w_mtc0 && (A2 == c_reg_epc);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sr_im     <= 6'd0;
      r_sr_exl    <= 1'b0;
      r_sr_ie     <= 1'b0;
      r_cause_bd  <= 1'b0;
      r_cause_ip  <= 6'd0;
      r_cause_exc <= 5'd0;
      r_epc       <= 32'd0;
    end else begin
      r_cause_ip <= w_int_lines;
      if (IntReq) begin
        r_sr_exl    <= 1'b1;
        r_epc       <= {EPC_in[31:2], 2'b00};
        r_cause_bd  <= BD_in;
        // Interrupt takes priority over a synchronous exception.
        r_cause_exc <= w_int_pend ? 5'd0 : ExcCode_in;
      end else begin
        if (w_wr_sr) begin
          r_sr_im  <= DIn[15:10];
          r_sr_exl <= DIn[1];
          r_sr_ie  <= DIn[0];
        end
        if (w_wr_epc) r_epc <= DIn;
        // eret clear overrides an mtc0 value written to EXL this cycle.
        if (EXLClr) r_sr_exl <= 1'b0;
      end
    end
  end

  assign w_sr    = {16'd0, r_sr_im, 8'd0, r_sr_exl, r_sr_ie};
  assign w_cause = {r_cause_bd, 15'd0, r_cause_ip, 3'd0, r_cause_exc, 2'b00};
  assign EPC_out = r_epc;

  // Read data reflects state before the edge; no write bypass.
  always_comb begin
    DOut = 32'd0;
    case (A1)
`ifdef CP0_TIMER_EN
      c_reg_count:   DOut = r_count;
      c_reg_compare: DOut = r_compare;
`endif
      c_reg_sr:      DOut = w_sr;
      c_reg_cause:   DOut = w_cause;
      c_reg_epc:     DOut = r_epc;
      c_reg_prid:    DOut = PRID_VAL;
      default:       DOut = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cp0_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_unit
// Purpose  : Self-checking bench for cp0_unit. Each table row is one clock
//            cycle of stimulus; expected combinational outputs for that cycle
//            are queued when the row is driven and compared mid-cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_unit;

  logic        clk;
  logic        reset_n;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] EPC_in;
  logic        BD_in;
  logic [4:0]  ExcCode_in;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC_out;
  logic [31:0] DOut;

  int checks = 0;
  int errors = 0;

  cp0_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .A1         (A1),
    .A2         (A2),
    .DIn        (DIn),
    .WE         (WE),
    .EPC_in     (EPC_in),
    .BD_in      (BD_in),
    .ExcCode_in (ExcCode_in),
    .HWInt      (HWInt),
    .EXLClr     (EXLClr),
    .IntReq     (IntReq),
    .EPC_out    (EPC_out),
    .DOut       (DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] epc_in;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        clr;
    logic        x_int;
    logic [31:0] x_dout;
    logic [31:0] x_epc;
  } vec_t;

  typedef struct {
    int          row;
    logic        x_int;
    logic [31:0] x_dout;
    logic [31:0] x_epc;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[$];

  function automatic vec_t mk(logic rst_n, logic [4:0] a1, logic [4:0] a2,
                              logic [31:0] din, logic we, logic [31:0] epc_in,
                              logic bd, logic [4:0] exc, logic [5:0] hw,
                              logic clr, logic x_int, logic [31:0] x_dout,
                              logic [31:0] x_epc);
    vec_t v;
    v.rst_n = rst_n; v.a1 = a1; v.a2 = a2; v.din = din; v.we = we;
    v.epc_in = epc_in; v.bd = bd; v.exc = exc; v.hw = hw; v.clr = clr;
    v.x_int = x_int; v.x_dout = x_dout; v.x_epc = x_epc;
    return v;
  endfunction

  task automatic check1(string name, int row, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, want);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare mid-cycle.
  task automatic step(vec_t v, int row);
    exp_t e;
    exp_t g;
    @(posedge clk);
    #1;
    reset_n = v.rst_n; A1 = v.a1; A2 = v.a2; DIn = v.din; WE = v.we;
    EPC_in = v.epc_in; BD_in = v.bd; ExcCode_in = v.exc; HWInt = v.hw;
    EXLClr = v.clr;
    e.row = row; e.x_int = v.x_int; e.x_dout = v.x_dout; e.x_epc = v.x_epc;
    exp_q.push_back(e);
    @(negedge clk);
    g = exp_q.pop_front();
    check1("IntReq",  g.row, {31'd0, IntReq}, {31'd0, g.x_int});
    check1("DOut",    g.row, DOut,    g.x_dout);
    check1("EPC_out", g.row, EPC_out, g.x_epc);
  endtask

  initial begin
    reset_n = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; WE = 1'b0;
    EPC_in = 32'd0; BD_in = 1'b0; ExcCode_in = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    repeat (2) @(posedge clk);

    //            rst a1  a2  din            we epc_in        bd exc  hw     clr  int dout           epc
    vecs.push_back(mk(1, 12, 0, 32'h0,         0, 32'h0,        0, 0,  6'h00, 0,   0, 32'h0,         32'h0));    // 1 reset SR
    vecs.push_back(mk(1, 13, 0, 32'h0,         0, 32'h0,        0, 0,  6'h00, 0,   0, 32'h0,         32'h0));    // 2 reset Cause
    vecs.push_back(mk(1, 14, 0, 32'h0,         0, 32'h0,        0, 0,  6'h00, 0,   0, 32'h0,         32'h0));    // 3 reset EPC
    vecs.push_back(mk(1, 15, 0, 32'h0,         0, 32'h0,        0, 0,  6'h00, 0,   0, 32'h0000_2019, 32'h0));    // 4 PRId
    vecs.push_back(mk(1,  7, 0, 32'h0,         0, 32'h0,        0, 0,  6'h00, 0,   0, 32'h0,         32'h0));    // 5 unimpl
    vecs.push_back(mk(1, 12, 12, 32'h401,      1, 32'h0,        0, 0,  6'h01, 0,   0, 32'h0,         32'h0));    // 6 mtc0 SR
    vecs.push_back(mk(1, 12, 0, 32'h0,         0, 32'h100,      0, 0,  6'h01, 0,   1, 32'h401,       32'h0));    // 7 irq taken
    vecs.push_back(mk(1, 12, 0, 32'h0,         0, 32'h0,        0, 0,  6'h01, 0,   0, 32'h403,       32'h100));  // 8 EXL set
    vecs.push_back(mk(1, 13, 0, 32'h0,         0, 32'h0,        0, 0,  6'h01, 0,   0, 32'h400,       32'h100));  // 9 IP=1 code 0
    vecs.push_back(mk(1, 12, 0, 32'h0,         0, 32'h0,        0, 0,  6'h01, 1,   0, 32'h403,       32'h100));  // 10 eret, no irq
    vecs.push_back(mk(1, 12, 0, 32'h0,         0, 32'h200,      0, 0,  6'h01, 0,   1, 32'h401,       32'h100));  // 11 irq again
    vecs.push_back(mk(1, 14, 0, 32'h0,         0, 32'h0,        0, 0,  6'h00, 1,   0, 32'h200,       32'h200));  // 12 eret
    vecs.push_back(mk(1, 12, 0, 32'h0,         0, 32'h3007,     1, 4,  6'h00, 0,   1, 32'h401,       32'h200));  // 13 sync exc
    vecs.push_back(mk(1, 13, 0, 32'h0,         0, 32'h0,        0, 5,  6'h00, 0,   0, 32'h8000_0010, 32'h3004)); // 14 Cause, exc masked
    vecs.push_back(mk(1, 12, 0, 32'h0,         0, 32'h0,        0, 0,  6'h00, 1,   0, 32'h403,       32'h3004)); // 15 eret
    vecs.push_back(mk(1, 14, 14, 32'h1234,     1, 32'h5008,     0, 10, 6'h00, 0,   1, 32'h3004,      32'h3004)); // 16 exc beats mtc0
    vecs.push_back(mk(1, 14, 14, 32'h1234,     1, 32'h0,        0, 0,  6'h00, 0,   0, 32'h5008,      32'h5008)); // 17 mtc0 EPC
    vecs.push_back(mk(1, 13, 0, 32'h0,         0, 32'h0,        0, 0,  6'h00, 0,   0, 32'h28,        32'h1234)); // 18 code 10
    vecs.push_back(mk(1, 12, 12, 32'hFFFF_FFFF, 1, 32'h0,       0, 0,  6'h00, 1,   0, 32'h403,       32'h1234)); // 19 mtc0 SR + eret
    vecs.push_back(mk(1, 12, 0, 32'h0,         0, 32'h6000,     0, 7,  6'h20, 0,   1, 32'h0000_FC01, 32'h1234)); // 20 irq+exc
    vecs.push_back(mk(1, 13, 0, 32'h0,         0, 32'h0,        0, 0,  6'h20, 0,   0, 32'h8000,      32'h6000)); // 21 irq priority
    vecs.push_back(mk(1, 13, 13, 32'hFFFF_FFFF, 1, 32'h0,       0, 0,  6'h00, 0,   0, 32'h8000,      32'h6000)); // 22 Cause RO
    vecs.push_back(mk(1, 13, 7, 32'hDEAD,      1, 32'h0,        0, 0,  6'h00, 0,   0, 32'h0,         32'h6000)); // 23 IP follows
    vecs.push_back(mk(1,  7, 0, 32'h0,         0, 32'h0,        0, 0,  6'h00, 1,   0, 32'h0,         32'h6000)); // 24 unimpl write
    vecs.push_back(mk(1, 12, 12, 32'h400,      1, 32'h0,        0, 0,  6'h00, 0,   0, 32'h0000_FC01, 32'h6000)); // 25 IE off
    vecs.push_back(mk(1, 12, 12, 32'h801,      1, 32'h0,        0, 0,  6'h01, 0,   0, 32'h400,       32'h6000)); // 26 IE=0 blocks
    vecs.push_back(mk(1, 12, 0, 32'h0,         0, 32'h0,        0, 0,  6'h01, 0,   0, 32'h801,       32'h6000)); // 27 IM masks
    vecs.push_back(mk(1, 12, 0, 32'h0,         0, 32'h7000,     0, 0,  6'h02, 0,   1, 32'h801,       32'h6000)); // 28 line 1
    vecs.push_back(mk(0, 12, 0, 32'h0,         0, 32'h0,        0, 0,  6'h00, 0,   0, 32'h803,       32'h7000)); // 29 reset in handler
    vecs.push_back(mk(1, 12, 0, 32'h0,         0, 32'h0,        0, 0,  6'h00, 0,   0, 32'h0,         32'h0));    // 30
    vecs.push_back(mk(1, 13, 0, 32'h0,         0, 32'h0,        0, 0,  6'h00, 0,   0, 32'h0,         32'h0));    // 31
    vecs.push_back(mk(1, 15, 0, 32'h0,         0, 32'h0,        0, 0,  6'h00, 0,   0, 32'h0000_2019, 32'h0));    // 32

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i + 1);

`ifdef CP0_TIMER_EN
    begin
      int waited;
      logic seen;
      step(mk(1, 0, 11, 32'd5,    1, 0, 0, 0, 6'h00, 0, 0, 32'h0, 32'h0), 100); // Compare = 5
      step(mk(1, 0,  9, 32'd0,    1, 0, 0, 0, 6'h00, 0, 0, 32'h0, 32'h0), 101); // Count = 0
      step(mk(1, 9, 12, 32'h8001, 1, 0, 0, 0, 6'h00, 0, 0, 32'h0, 32'h0), 102); // SR, Count reads 0
      seen = 1'b0;
      waited = 0;
      while (!seen && waited < 20) begin
        @(posedge clk);
        #1;
        WE = 1'b0; A1 = 5'd13;
        @(negedge clk);
        seen = IntReq;
        waited++;
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL timer_irq: IntReq got 0 expected 1 within 20 cycles");
      end
      // Request taken at the edge; IP[15] shows the timer line.
      step(mk(1, 13, 11, 32'h100, 1, 0, 0, 0, 6'h00, 1, 0, 32'h8000, 32'h0), 103);
      step(mk(1, 12, 0, 32'h0,    0, 0, 0, 0, 6'h00, 0, 0, 32'h8001, 32'h0), 104);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
